// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, buffers imem words in a
// small FIFO and hands {pc, instr, fault} to decode over valid/ready.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault,
    output logic [31:0] fetch_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    state_t      state;
    logic        fault_pend;
    logic [31:0] pc;

    logic [31:0] buf_pc    [FIFO_DEPTH];
    logic [31:0] buf_instr [FIFO_DEPTH];
    logic        buf_fault [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic pop;
    logic push_run;
    logic push_fault;
    logic push;
    logic [31:0] wr_instr;

    // Handshake and push qualification; redirect overrides everything
    always_comb begin
        pop        = (count != '0) && if_ready;
        push_run   = !redirect_valid && (state == RUN) && fetch_en
                     && ((count < DEPTH) || pop);
        push_fault = !redirect_valid && fault_pend;
        push       = push_run || push_fault;
        wr_instr   = push_fault ? NOP : imem_instr;
    end

    // PC, fetch state and fault-entry scheduling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            state      <= RUN;
            fault_pend <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc;
            if (redirect_pc[1:0] == 2'b00) begin
                state      <= RUN;
                fault_pend <= 1'b0;
            end else begin
                state      <= FAULT;
                fault_pend <= 1'b1;
            end
        end else begin
            fault_pend <= 1'b0;
            if (push_run) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // Fetch buffer storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
                buf_fault[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]    <= pc;
                buf_instr[wr_ptr] <= wr_instr;
                buf_fault[wr_ptr] <= push_fault;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Count of accepted entries; flushed pops are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (!redirect_valid && pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign imem_addr = pc;
    assign if_valid  = (count != '0);
    assign if_pc     = buf_pc[rd_ptr];
    assign if_instr  = buf_instr[rd_ptr];
    assign if_fault  = buf_fault[rd_ptr];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a small behavioural imem.
// Samples 1 time unit after each rising edge.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;
    logic [31:0] fetch_count;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0: rom = 32'h0050_0093;
            32'h4: rom = 32'h0060_0113;
            32'h8: rom = 32'h0020_81b3;
            32'hC: rom = 32'h4021_8233;
            default: rom = 32'h0000_0013;
        endcase
    endfunction

    assign imem_instr = rom(imem_addr);

    imem_fetch_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .if_fault(if_fault),
        .fetch_count(fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // reset state
        step();
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_fault", {31'b0, if_fault}, 32'd0);
        check("rst_cnt", fetch_count, 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // 1: straight-line stream
        rst_n = 1'b1;
        step();
        check("t1_pc0", if_pc, 32'h0);
        check("t1_in0", if_instr, 32'h0050_0093);
        step();
        check("t1_pc1", if_pc, 32'h4);
        check("t1_in1", if_instr, 32'h0060_0113);
        step();
        check("t1_pc2", if_pc, 32'h8);
        check("t1_in2", if_instr, 32'h0020_81b3);
        step();
        check("t1_pc3", if_pc, 32'hC);
        check("t1_in3", if_instr, 32'h4021_8233);
        check("t1_v3", {31'b0, if_valid}, 32'd1);
        step();
        check("t1_cnt", fetch_count, 32'd4);

        // 2: backpressure
        do_reset();
        step();
        check("t2_first", if_pc, 32'h0);
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_pc", if_pc, 32'h0);
            check("t2_hold_in", if_instr, 32'h0050_0093);
            check("t2_addr", imem_addr, 32'h8);
        end
        if_ready = 1'b1;
        step();
        check("t2_rel_pc", if_pc, 32'h4);
        check("t2_rel_in", if_instr, 32'h0060_0113);
        check("t2_cnt", fetch_count, 32'd1);

        // 3: aligned redirect with FIFO holding 0x4,0x8
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        step();
        redirect_valid = 1'b0;
        check("t3_flush_v", {31'b0, if_valid}, 32'd0);
        check("t3_flush_cnt", fetch_count, 32'd1);
        check("t3_addr", imem_addr, 32'hC);
        step();
        check("t3_v", {31'b0, if_valid}, 32'd1);
        check("t3_pc", if_pc, 32'hC);
        check("t3_in", if_instr, 32'h4021_8233);
        check("t3_cnt", fetch_count, 32'd1);

        // 4: misaligned redirect -> single fault entry
        redirect_valid = 1'b1;
        redirect_pc    = 32'h5;
        step();
        redirect_valid = 1'b0;
        check("t4_flush_v", {31'b0, if_valid}, 32'd0);
        check("t4_addr", imem_addr, 32'h5);
        step();
        check("t4_fv", {31'b0, if_valid}, 32'd1);
        check("t4_fpc", if_pc, 32'h5);
        check("t4_fin", if_instr, 32'h0000_0013);
        check("t4_ff", {31'b0, if_fault}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_idle_v", {31'b0, if_valid}, 32'd0);
            check("t4_idle_a", imem_addr, 32'h5);
        end
        check("t4_cnt", fetch_count, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("t4_exit_v", {31'b0, if_valid}, 32'd0);
        step();
        check("t4_res_pc", if_pc, 32'h0);
        check("t4_res_in", if_instr, 32'h0050_0093);
        check("t4_res_f", {31'b0, if_fault}, 32'd0);

        // 5: fetch_en=0 drains buffered entries
        if_ready = 1'b0;
        do_reset();
        step();
        step();
        check("t5_addr0", imem_addr, 32'h8);
        fetch_en = 1'b0;
        if_ready = 1'b1;
        step();
        check("t5_d1", if_pc, 32'h4);
        step();
        check("t5_empty", {31'b0, if_valid}, 32'd0);
        check("t5_addr1", imem_addr, 32'h8);
        step();
        check("t5_addr2", imem_addr, 32'h8);
        check("t5_cnt", fetch_count, 32'd2);
        fetch_en = 1'b1;
        step();
        check("t5_res_pc", if_pc, 32'h8);
        check("t5_res_in", if_instr, 32'h0020_81b3);

        // 6: async reset mid-stream
        step();
        rst_n = 1'b0;
        #2;
        check("t6_v", {31'b0, if_valid}, 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_cnt", fetch_count, 32'd0);
        step();
        rst_n = 1'b1;

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
